fu_burst_driver: RTL and testbench

Host-side counterpart to the single-FU TP-FU core. It pulls 16-bit words from an upstream first-word-fall-through (FWFT) FIFO and buffers one full burst locally. It then drives that burst into the FU as one contiguous `valid` run. The FU starts executing when `valid` falls, so any gap inside the run would split the burst. The block then captures the FU result stream (`dout`/`dout_v`, which cannot be backpressured) and drains the results to a downstream FIFO under full-flag flow control.

---
 rtl/fu_burst_driver.sv | 207 ++++++++++++++++++++
 tb/tb_fu_burst_driver.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_burst_driver.sv
// Buffers one FWFT burst, sends it to the FU as a single valid run,
// then collects and drains the results. Option: FU_BURST_HEADER_EN.
module fu_burst_driver #(
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 8,
  parameter int RES_LEN   = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_empty,
  output logic              in_rd_en,
  output logic [DATA_W-1:0] fu_din,
  output logic              fu_valid,
  input  logic [DATA_W-1:0] fu_dout,
  input  logic              fu_dout_v,
  output logic [DATA_W-1:0] out_data,
  output logic              out_wr_en,
  input  logic              out_full,
  output logic              busy,
  output logic              err_timeout
);

  localparam int LW = $clog2(BURST_LEN + 1);
  localparam int AW = $clog2(BURST_LEN);
  localparam int RW = $clog2(RES_LEN + 1);
  localparam int RA = (RES_LEN > 1) ? $clog2(RES_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT);
`ifdef FU_BURST_HEADER_EN
  localparam int DW = $clog2(RES_LEN + 2);
`else
  localparam int DW = RW;
`endif

  localparam logic [LW-1:0] BL      = LW'(BURST_LEN);
  localparam logic [LW-1:0] BL1     = LW'(BURST_LEN - 1);
  localparam logic [RW-1:0] RES_MAX = RW'(RES_LEN);
  localparam logic [TW-1:0] TO1     = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEND, S_GAP, S_COLL, S_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [LW-1:0]     ld_cnt_q, ld_cnt_d;
  logic [RW-1:0]     res_cnt_q, res_cnt_d;
  logic [DW-1:0]     dr_cnt_q, dr_cnt_d;
  logic [TW-1:0]     to_cnt_q, to_cnt_d;
  logic [DATA_W-1:0] fu_din_q, fu_din_d;
  logic              fu_valid_q, fu_valid_d;
  logic              err_q, err_d;
  logic              cap;
  logic [DATA_W-1:0] wbuf_q [BURST_LEN];
  logic [DATA_W-1:0] wbuf_d [BURST_LEN];
  logic [DATA_W-1:0] rbuf_q [RES_LEN];
  logic [DATA_W-1:0] rbuf_d [RES_LEN];
`ifdef FU_BURST_HEADER_EN
  logic              berr_q, berr_d;
  logic [DW-1:0]     total;
  logic [DATA_W-1:0] hdr;
`endif

  always_comb begin
    state_d    = state_q;
    ld_cnt_d   = ld_cnt_q;
    res_cnt_d  = res_cnt_q;
    dr_cnt_d   = dr_cnt_q;
    to_cnt_d   = to_cnt_q;
    fu_din_d   = fu_din_q;
    fu_valid_d = fu_valid_q;
    err_d      = err_q;
    wbuf_d     = wbuf_q;
    rbuf_d     = rbuf_q;
    in_rd_en   = 1'b0;
    out_wr_en  = 1'b0;
    out_data   = '0;
`ifdef FU_BURST_HEADER_EN
    berr_d     = berr_q;
    total      = DW'(res_cnt_q) + DW'(1);
    hdr        = '0;
    hdr[DATA_W-1] = berr_q;
    hdr[7:0]   = 8'(res_cnt_q);
`endif

    // Results are accepted from the last SEND cycle through COLLECT.
    cap = fu_dout_v && (res_cnt_q != RES_MAX) &&
          ((state_q == S_SEND && ld_cnt_q == BL) ||
           state_q == S_GAP || state_q == S_COLL);
    if (cap) begin
      rbuf_d[RA'(res_cnt_q)] = fu_dout;
      res_cnt_d = res_cnt_q + RW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (!in_empty) begin
          state_d  = S_LOAD;
          ld_cnt_d = '0;
        end
      end
      S_LOAD: begin
        in_rd_en = !in_empty;
        if (!in_empty) begin
          wbuf_d[AW'(ld_cnt_q)] = in_data;
          ld_cnt_d = ld_cnt_q + LW'(1);
          if (ld_cnt_q == BL1) begin
            state_d    = S_SEND;
            ld_cnt_d   = LW'(1);
            fu_valid_d = 1'b1;
            fu_din_d   = wbuf_q[0];
            res_cnt_d  = '0;
`ifdef FU_BURST_HEADER_EN
            berr_d     = 1'b0;
`endif
          end
        end
      end
      S_SEND: begin
        if (ld_cnt_q == BL) begin
          state_d    = S_GAP;
          fu_valid_d = 1'b0;
          fu_din_d   = '0;
        end else begin
          fu_din_d = wbuf_q[AW'(ld_cnt_q)];
          ld_cnt_d = ld_cnt_q + LW'(1);
        end
      end
      S_GAP: begin
        state_d  = S_COLL;
        to_cnt_d = '0;
      end
      S_COLL: begin
        to_cnt_d = to_cnt_q + TW'(1);
        if (res_cnt_d == RES_MAX) begin
          state_d  = S_DRAIN;
          dr_cnt_d = '0;
        end else if (to_cnt_q == TO1) begin
          state_d  = S_DRAIN;
          dr_cnt_d = '0;
          err_d    = 1'b1;
`ifdef FU_BURST_HEADER_EN
          berr_d   = 1'b1;
`endif
        end
      end
      S_DRAIN: begin
`ifdef FU_BURST_HEADER_EN
        if (dr_cnt_q != total) begin
          out_data  = (dr_cnt_q == '0) ? hdr :
                      rbuf_q[RA'(dr_cnt_q - DW'(1))];
          out_wr_en = !out_full;
          if (!out_full) dr_cnt_d = dr_cnt_q + DW'(1);
        end
        if (dr_cnt_d == total) state_d = S_IDLE;
`else
        if (dr_cnt_q != res_cnt_q) begin
          out_data  = rbuf_q[RA'(dr_cnt_q)];
          out_wr_en = !out_full;
          if (!out_full) dr_cnt_d = dr_cnt_q + DW'(1);
        end
        if (dr_cnt_d == res_cnt_q) state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ld_cnt_q   <= '0;
      res_cnt_q  <= '0;
      dr_cnt_q   <= '0;
      to_cnt_q   <= '0;
      fu_din_q   <= '0;
      fu_valid_q <= 1'b0;
      err_q      <= 1'b0;
`ifdef FU_BURST_HEADER_EN
      berr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ld_cnt_q   <= ld_cnt_d;
      res_cnt_q  <= res_cnt_d;
      dr_cnt_q   <= dr_cnt_d;
      to_cnt_q   <= to_cnt_d;
      fu_din_q   <= fu_din_d;
      fu_valid_q <= fu_valid_d;
      err_q      <= err_d;
`ifdef FU_BURST_HEADER_EN
      berr_q     <= berr_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    wbuf_q <= wbuf_d;
    rbuf_q <= rbuf_d;
  end

  assign fu_din      = fu_din_q;
  assign fu_valid    = fu_valid_q;
  assign busy        = (state_q != S_IDLE);
  assign err_timeout = err_q;

endmodule

// File: tb/tb_fu_burst_driver.sv
// Randomized bench for fu_burst_driver with a queue-based burst/result
// model; FU and both FIFOs are modelled inside the bench.
module tb_fu_burst_driver;

  localparam int BL  = 8;
  localparam int RES = 4;
`ifdef FU_BURST_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam longint NEVER = 64'd1 << 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_empty;
  logic        in_rd_en;
  logic [15:0] fu_din;
  logic        fu_valid;
  logic [15:0] fu_dout;
  logic        fu_dout_v;
  logic [15:0] out_data;
  logic        out_wr_en;
  logic        out_full;
  logic        busy;
  logic        err_timeout;

  fu_burst_driver dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_empty(in_empty), .in_rd_en(in_rd_en),
    .fu_din(fu_din), .fu_valid(fu_valid),
    .fu_dout(fu_dout), .fu_dout_v(fu_dout_v),
    .out_data(out_data), .out_wr_en(out_wr_en), .out_full(out_full),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] up_q[$];
  logic [15:0] exp_fu[$];
  logic [15:0] exp_out[$];
  logic [15:0] sent_log[$];
  longint      pend_t[$];
  logic [15:0] pend_v[$];

  longint cyc = 0;
  longint full_cyc = 0;
  longint gap_cyc = 0;
  longint err_rise = 0;
  longint err_at = NEVER;
  int     run_len = 0;
  int     pops = 0;
  int     runs_done = 0;
  int     out_cnt = 0;
  bit     pop_now = 0;
  bit     rst_low_prev = 0;
  bit     err_prev = 0;
  bit     rand_fu = 0;
  int     fu_n = 4;
  int     fu_start = 4;
  int     stall_pct = 0;
  int     full_pct = 0;
  bit     full_force = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(string nm);
    checks++;
    errors++;
    $display("FAIL %s: got event want none", nm);
  endtask

  // The FU answers a completed burst with n results; the first RES are kept.
  task automatic complete_burst();
    int n, st, kept;
    longint t;
    logic [15:0] v, h;
    logic [15:0] res[$];
    n  = rand_fu ? int'($urandom_range(6)) : fu_n;
    st = rand_fu ? int'($urandom_range(4)) : fu_start;
    t  = cyc + st;
    for (int k = 0; k < n; k++) begin
      v = 16'($urandom);
      pend_t.push_back(t);
      pend_v.push_back(v);
      if (k < RES) res.push_back(v);
      t += rand_fu ? longint'($urandom_range(1, 3)) : 1;
    end
    kept = (n < RES) ? n : RES;
    if (HDR == 1) begin
      h = '0;
      h[15] = (n < RES);
      h[7:0] = 8'(kept);
      exp_out.push_back(h);
    end
    foreach (res[i]) exp_out.push_back(res[i]);
    if (n < RES && err_at > cyc + 66) err_at = cyc + 66;
    runs_done++;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst_low_prev) begin
      chk("rst_fu_valid", fu_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_rd_en", in_rd_en, 0);
      chk("rst_out_wr_en", out_wr_en, 0);
      chk("rst_fu_din", fu_din, 0);
    end
    chk("err_timeout", err_timeout, (cyc >= err_at) ? 1 : 0);
    if (err_timeout === 1'b1 && !err_prev) err_rise = cyc;
    err_prev = (err_timeout === 1'b1);

    pop_now = 0;
    if (in_rd_en === 1'b1) begin
      chk("rd_en_when_empty", in_empty, 0);
      if (rst && !in_empty) begin
        pop_now = 1;
        exp_fu.push_back(in_data);
        pops++;
        if (pops == BL) begin
          pops = 0;
          full_cyc = cyc;
        end
      end
    end

    if (fu_valid === 1'b1) begin
      chk("busy_in_send", busy, 1);
      if (run_len == 0) chk("send_latency", 32'(cyc - full_cyc), 1);
      run_len++;
      if (exp_fu.size() == 0) fail_now("fu_din_unexpected");
      else chk("fu_din", fu_din, exp_fu.pop_front());
      sent_log.push_back(fu_din);
      if (run_len == BL) complete_burst();
    end else begin
      if (run_len != 0) begin
        chk("valid_run_len", run_len, BL);
        gap_cyc = cyc;
      end
      run_len = 0;
    end

    if (out_wr_en === 1'b1) begin
      chk("wr_en_when_full", out_full, 0);
      out_cnt++;
      if (exp_out.size() == 0) fail_now("out_unexpected");
      else chk("out_data", out_data, exp_out.pop_front());
    end

    if (pend_t.size() != 0 && pend_t[0] == cyc) begin
      fu_dout_v = 1'b1;
      fu_dout = pend_v.pop_front();
      void'(pend_t.pop_front());
    end else begin
      fu_dout_v = 1'b0;
      fu_dout = 16'($urandom);
    end

    if (!rst) begin
      exp_fu.delete();
      exp_out.delete();
      pend_t.delete();
      pend_v.delete();
      run_len = 0;
      pops = 0;
      err_at = NEVER;
      pop_now = 0;
    end
    rst_low_prev = !rst;
  end

  task automatic drive_up();
    bit stall;
    stall = ($urandom_range(99) < stall_pct);
    in_empty = (up_q.size() == 0) || stall;
    in_data = (up_q.size() != 0) ? up_q[0] : 16'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pop_now) begin
      void'(up_q.pop_front());
      pop_now = 0;
    end
    out_full = full_force || ($urandom_range(99) < full_pct);
    drive_up();
  endtask

  task automatic push_burst(int base, bit rnd);
    for (int i = 0; i < BL; i++)
      up_q.push_back(rnd ? 16'($urandom) : 16'(base + i));
    drive_up();
  endtask

  task automatic wait_idle(int max);
    bit done;
    done = 0;
    for (int i = 0; i < max && !done; i++) begin
      if (up_q.size() == 0 && busy === 1'b0 &&
          pend_t.size() == 0 && exp_out.size() == 0) done = 1;
      else tick();
    end
    if (!done) fail_now("wait_idle_timeout");
  endtask

  task automatic wait_run(int r0, int max);
    bit done;
    done = 0;
    for (int i = 0; i < max && !done; i++) begin
      if (runs_done != r0) done = 1;
      else tick();
    end
    if (!done) fail_now("wait_run_timeout");
  endtask

  task automatic chk_log(string nm, int base);
    chk({nm, "_len"}, sent_log.size(), BL);
    if (sent_log.size() == BL)
      for (int i = 0; i < BL; i++) chk(nm, sent_log[i], base + i);
  endtask

  int o0, o1, r0;
  bit found;

  initial begin
    rst = 1'b0;
    in_data = '0;
    in_empty = 1'b1;
    fu_dout = '0;
    fu_dout_v = 1'b0;
    out_full = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("reset_busy", busy, 0);
    chk("reset_valid", fu_valid, 0);
    chk("reset_err", err_timeout, 0);

    // 1: clean burst 1..8, results 3 cycles after valid falls
    fu_n = 4; fu_start = 4;
    sent_log.delete(); o0 = out_cnt; r0 = runs_done;
    push_burst(1, 0);
    wait_idle(1000);
    chk("s1_runs", runs_done - r0, 1);
    chk("s1_writes", out_cnt - o0, RES + HDR);
    chk("s1_busy_after", busy, 0);
    chk_log("s1_word", 1);

    // 2: upstream stalls during LOAD
    stall_pct = 60; o0 = out_cnt; r0 = runs_done;
    push_burst(16'h100, 0);
    wait_idle(1000);
    stall_pct = 0;
    chk("s2_runs", runs_done - r0, 1);
    chk("s2_writes", out_cnt - o0, RES + HDR);

    // 3: downstream full while DRAIN is pending
    full_force = 1; o0 = out_cnt; r0 = runs_done;
    push_burst(16'h200, 0);
    wait_run(r0, 500);
    repeat (10) tick();
    repeat (10) tick();
    chk("s3_no_write_full", out_cnt - o0, 0);
    chk("s3_busy_held", busy, 1);
    full_force = 0;
    wait_idle(1000);
    chk("s3_writes", out_cnt - o0, RES + HDR);

    // 6: extra result pulses
    fu_n = 6; o0 = out_cnt;
    push_burst(16'h300, 0);
    wait_idle(1000);
    chk("s6_writes", out_cnt - o0, RES + HDR);
    chk("s6_err", err_timeout, 0);

    // 4: short result stream times out, next burst still runs
    fu_n = 2; o0 = out_cnt;
    push_burst(16'h400, 0);
    wait_idle(1000);
    chk("s4_err", err_timeout, 1);
    chk("s4_writes", out_cnt - o0, 2 + HDR);
    chk("s4_err_delay", 32'(err_rise - gap_cyc), 65);
    fu_n = 4; o0 = out_cnt; r0 = runs_done;
    push_burst(16'h500, 0);
    wait_idle(1000);
    chk("s4_next_runs", runs_done - r0, 1);
    chk("s4_next_writes", out_cnt - o0, RES + HDR);
    chk("s4_err_sticky", err_timeout, 1);

    // 5: reset on the 4th SEND cycle
    fu_n = 4;
    push_burst(16'h600, 0);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (fu_valid === 1'b1 && run_len == 3) found = 1;
    end
    if (!found) fail_now("s5_send_not_seen");
    rst = 1'b0;
    tick();
    chk("s5_valid_at_rst", fu_valid, 0);
    chk("s5_busy_at_rst", busy, 0);
    chk("s5_err_cleared", err_timeout, 0);
    rst = 1'b1;
    tick();
    sent_log.delete(); o0 = out_cnt; r0 = runs_done;
    push_burst(16'h21, 0);
    wait_idle(1000);
    chk("s5_runs", runs_done - r0, 1);
    chk("s5_writes", out_cnt - o0, RES + HDR);
    chk_log("s5_word", 16'h21);

    // randomized bursts, stalls and backpressure
    rand_fu = 1; stall_pct = 30; full_pct = 25;
    for (int it = 0; it < 12; it++) begin
      push_burst(0, 1);
      if ($urandom_range(1) == 1) push_burst(0, 1);
      wait_idle(4000);
    end

    chk("end_exp_out_empty", exp_out.size(), 0);
    chk("end_exp_fu_empty", exp_fu.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
